// File: rtl/sub_serial.sv
// Bit-serial subtractor: loads a/b on start, emits a-b LSB first over WIDTH clocks.
// Optional signed-overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
`ifdef SUB_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_borrow;
    logic [CW-1:0]    r_count;

    logic w_start;
    logic w_step;
    logic w_diff;
    logic w_borrow_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Unused encoding 3 falls through to default and recovers to IDLE.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = en ? SUB : IDLE;
            SUB:     w_next = (r_count == LAST) ? DONE : SUB;
            DONE:    w_next = en ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_start     = (r_state == IDLE) && en;
    assign w_step      = (r_state == SUB);
    assign w_diff      = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nx = (~r_a[0] & r_b[0]) | (~r_a[0] & r_borrow) | (r_b[0] & r_borrow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (w_start) begin
            r_a      <= a;
            r_b      <= b;
            r_out    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (w_step) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_out    <= {w_diff, r_out[WIDTH-1:1]};
            r_borrow <= w_borrow_nx;
            r_count  <= r_count + CW'(1);
        end
    end

    assign out        = r_out;
    assign busy       = (r_state == SUB);
    assign done       = (r_state == DONE);
    assign borrow_out = done & r_borrow;

`ifdef SUB_SERIAL_OVF_EN
    logic r_a_msb;
    logic r_b_msb;

    // Operand MSBs are kept separately since r_a/r_b are shifted away during SUB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end
    end

    assign ovf = done && (r_a_msb != r_b_msb) && (r_out[WIDTH-1] != r_a_msb);
`endif

endmodule
